mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits between the core's two memory requesters and the dual-SPRAM 32-bit memory block: instruction fetch (port IF, read-only) and load/store (port D, read/write).
- Arbitrates one access per cycle and converts byte address + size into word address, byte mask and lane-aligned write data.
- Extracts, aligns and sign/zero-extends read data, and routes the one-cycle-latency response back to the owning port.

Parameters:
- ADDR_BITS, 16, byte-address width of the memory (64 KiB = 16K words); word address is addr[ADDR_BITS-1:2].
- MEM_AW, 14, word-address width driven to the memory; must equal ADDR_BITS-2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address.
- if_resp_valid  out  1  fetch response.
- if_resp_data  out  32  fetched word.
- if_resp_err  out  1  fetch misaligned/out of range.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  32  data byte address.
- d_we  in  1  1 = store.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_unsigned  in  1  zero-extend loads.
- d_wdata  in  32  store data, right-aligned.
- d_resp_valid  out  1  data response, loads and stores.
- d_resp_data  out  32  extended load data; 0 for stores.
- d_resp_err  out  1  data access fault.
- mem_addr  out  MEM_AW  word address.
- mem_mask  out  4  byte-lane enable.
- mem_write  out  1  write strobe.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  raw word from memory, valid the cycle after issue.

Behaviour:
- Reset: all *_resp_valid, *_resp_err, mem_write and mem_mask are 0; resp data 0; pending register cleared; round-robin pointer favours D.
- Ready signals are combinational and are 0 while rst_n = 0.
- Grant:
  - At most one of if_req_ready / d_req_ready is high per cycle.
  - A port is ready only when it is valid and granted; there is no back-pressure from the memory.
  - Default policy: D has fixed priority over IF.
- Issue cycle T (valid & ready):
  - mem_addr, mem_mask, mem_write and mem_wdata are driven combinationally from the granted request in T.
  - Memory samples them at the end of T.
- Reads always use mem_mask = 1111 and mem_write = 0.
- Writes:
  - mem_mask = 0001 << addr[1:0] for a byte, 0011 << addr[1:0] for a half, 1111 for a word.
  - mem_wdata replicates the byte or half to every lane.
- Idle cycles: mem_mask = 0000 and mem_write = 0.
- Errors (checked in T):
  - Misaligned: half with addr[0] = 1, word with addr[1:0] != 0, or d_size = 11.
  - Out of range: addr[31:ADDR_BITS] != 0.
  - A faulting request is still accepted, but mem_mask = 0 and mem_write = 0.
- Pending register is captured at T: valid, port, err, we, size, offset, unsigned.
- Response in T+1:
  - resp_valid = 1 for exactly one cycle, on the owning port only.
  - err = pending err.
  - data = 0 if err or we; otherwise mem_rdata shifted right by 8*offset, then masked to size and sign/zero-extended.
- Throughput: back-to-back issue every cycle; the response of T and the issue of T+1 coexist.
- Both ports valid in the same cycle: only the grantee is accepted; the other holds its request stable until ready.
- Reset asserted mid-access clears the pending register; no response is emitted for the in-flight access.

Optional Feature:
- MEM_ARB_RR_EN defined: two-way round-robin replaces fixed priority.
  - Pointer toggles to the other port after each grant.
  - On simultaneous requests the non-last-granted port wins.
  - A lone requester is always granted.
- Undefined: fixed D-over-IF priority, with no pointer register.

Decomposition:
- Package MemArb (beside MemoryBus):
  - typedef enum Size {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD}.
  - typedef struct Pending.
  - constants LANES = 4, WORD_BYTES = 4.
- Sub-module mem_lane_align (combinational): computes the mask, replicated write data and read extraction/extension; reused by the future DMA port.
- Reuse uint32 from Common.

Test Plan:
- D store word 0x0000_0010 data 0xDEADBEEF, then D load word 0x10 -> T: mem_addr = 4, mask = 1111, write = 1; store resp data 0; load resp data 0xDEADBEEF at T+1.
- D store byte 0x13 data 0x000000A5, then load byte signed 0x13 -> mask 1000, wdata 0xA5A5A5A5; load resp 0xFFFFFFA5; unsigned load resp 0x000000A5.
- Store half at 0x21 -> accepted; no memory write (mask 0000); d_resp_err = 1, data 0 next cycle.
- IF and D both valid for 4 cycles:
  - Without MEM_ARB_RR_EN: D granted in all 4 cycles, IF starved.
  - With MEM_ARB_RR_EN: grants alternate D, IF, D, IF, and responses route to the matching ports.
- IF fetch at 0x0001_0000 -> if_resp_err = 1, mem_mask = 0000.
- IF fetch issued, then rst_n pulled low before the next clock edge -> no if_resp_valid; all outputs 0; first access after reset behaves normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory arbiter slice.
//   size_e    : access size encoding as presented on d_size.
//   port_e    : requester identity carried into the response stage.
//   pending_t : state of the access issued last cycle, consumed by the
//               one-cycle-latency response path.
//   uint32    : plain 32-bit word type.
package mem_arbiter_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [31:0] uint32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  typedef struct packed {
    logic       valid;
    port_e      port;
    logic       err;
    logic       we;
    size_e      size;
    logic [1:0] offset;
    logic       uns;
  } pending_t;

  // True when the byte offset does not suit the access size (or the size is illegal).
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = |offset;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane helper.
//   Write side: wr_size/wr_offset/wr_data -> wr_mask (lane enables) and
//               wr_lanes (byte/half replicated across all lanes).
//   Read side : rd_word shifted down by rd_offset bytes, truncated to rd_size
//               and sign- or zero-extended (rd_unsigned) into rd_data.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  size_e       wr_size,
  input  logic [1:0]  wr_offset,
  input  uint32       wr_data,
  output logic [3:0]  wr_mask,
  output uint32       wr_lanes,
  input  size_e       rd_size,
  input  logic [1:0]  rd_offset,
  input  logic        rd_unsigned,
  input  uint32       rd_word,
  output uint32       rd_data
);

  uint32 shifted;

  always_comb begin
    wr_mask  = '0;
    wr_lanes = '0;
    case (wr_size)
      SZ_BYTE: begin
        wr_mask  = 4'b0001 << wr_offset;
        wr_lanes = {LANES{wr_data[7:0]}};
      end
      SZ_HALF: begin
        wr_mask  = 4'b0011 << wr_offset;
        wr_lanes = {2{wr_data[15:0]}};
      end
      SZ_WORD: begin
        wr_mask  = 4'b1111;
        wr_lanes = wr_data;
      end
      default: begin
        wr_mask  = '0;
        wr_lanes = '0;
      end
    endcase
  end

  always_comb begin
    shifted = rd_word >> {rd_offset, 3'b000};
    rd_data = '0;
    case (rd_size)
      SZ_BYTE: rd_data = {{24{~rd_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rd_data = {{16{~rd_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_WORD: rd_data = shifted;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the instruction-fetch port (IF, read-only) and the
// load/store port (D) onto a single-ported 32-bit memory, one access per cycle.
//   if_*  : fetch request (valid/ready/addr) and response (valid/data/err).
//   d_*   : data request (valid/ready/addr/we/size/unsigned/wdata) and response.
//   mem_* : word address, byte mask, write strobe and lane data to the memory;
//           mem_rdata returns the word one cycle after issue.
// Build option MEM_ARB_RR_EN: two-way round-robin grant instead of fixed
// D-over-IF priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned MEM_AW    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_addr,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_data,
  output logic              d_resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_mask,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic     d_grant;
  logic     if_grant;
  logic     issue;
  port_e    sel_port;
  uint32    sel_addr;
  size_e    sel_size;
  logic     sel_we;
  logic     sel_uns;
  logic     sel_err;
  logic [3:0] wr_mask;
  uint32    wr_lanes;
  uint32    rd_data;
  pending_t pend;
  logic     load_ok;

`ifdef MEM_ARB_RR_EN
  // Last-granted port; reset to IF so that D wins the first contest.
  port_e last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_IF;
    end else if (issue) begin
      last_grant <= sel_port;
    end
  end

  always_comb begin
    d_grant  = d_req_valid;
    if_grant = if_req_valid;
    if (d_req_valid && if_req_valid) begin
      d_grant  = (last_grant == PORT_IF);
      if_grant = (last_grant == PORT_D);
    end
  end
`else
  always_comb begin
    d_grant  = d_req_valid;
    if_grant = if_req_valid & ~d_req_valid;
  end
`endif

  assign d_req_ready  = rst_n & d_grant;
  assign if_req_ready = rst_n & if_grant;
  assign issue        = d_req_ready | if_req_ready;

  // Granted request; IF is always a word read.
  always_comb begin
    if (d_grant) begin
      sel_port = PORT_D;
      sel_addr = d_addr;
      sel_size = size_e'(d_size);
      sel_we   = d_we;
      sel_uns  = d_unsigned;
    end else begin
      sel_port = PORT_IF;
      sel_addr = if_addr;
      sel_size = SZ_WORD;
      sel_we   = 1'b0;
      sel_uns  = 1'b0;
    end
    sel_err = is_misaligned(sel_size, sel_addr[1:0]) | ((sel_addr >> ADDR_BITS) != '0);
  end

  mem_lane_align u_align (
    .wr_size     (sel_size),
    .wr_offset   (sel_addr[1:0]),
    .wr_data     (d_wdata),
    .wr_mask     (wr_mask),
    .wr_lanes    (wr_lanes),
    .rd_size     (pend.size),
    .rd_offset   (pend.offset),
    .rd_unsigned (pend.uns),
    .rd_word     (mem_rdata),
    .rd_data     (rd_data)
  );

  // Faulting requests are accepted but never reach the memory.
  always_comb begin
    mem_addr  = '0;
    mem_mask  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (issue) begin
      mem_addr = sel_addr[ADDR_BITS-1:2];
      if (!sel_err) begin
        mem_mask  = sel_we ? wr_mask : 4'b1111;
        mem_write = sel_we;
        mem_wdata = sel_we ? wr_lanes : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (issue) begin
      pend <= '{valid: 1'b1, port: sel_port, err: sel_err, we: sel_we,
                size: sel_size, offset: sel_addr[1:0], uns: sel_uns};
    end else begin
      pend <= '0;
    end
  end

  assign load_ok       = ~pend.err & ~pend.we;
  assign if_resp_valid = pend.valid & (pend.port == PORT_IF);
  assign d_resp_valid  = pend.valid & (pend.port == PORT_D);
  assign if_resp_err   = if_resp_valid & pend.err;
  assign d_resp_err    = d_resp_valid & pend.err;
  assign if_resp_data  = (if_resp_valid & load_ok) ? rd_data : '0;
  assign d_resp_data   = (d_resp_valid & load_ok) ? rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte-array reference
// model checked every cycle, a word-wide memory emulation feeding mem_rdata,
// and literal expectations at key points of each scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_resp_data;
  logic        d_req_valid, d_req_ready, d_we, d_unsigned, d_resp_valid, d_resp_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_resp_data;
  logic [13:0] mem_addr;
  logic [3:0]  mem_mask;
  logic        mem_write;
  logic [31:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_BITS(16), .MEM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory emulation: masked synchronous write, registered read.
  logic [31:0] ram [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (mem_write && mem_mask[l]) ram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:65535];
  initial for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

  int unsigned last_port = 0;       // 0 = IF last granted, 1 = D
  bit          cur_v = 0, cur_port = 0, cur_err = 0;
  logic [31:0] cur_data = '0;

  function automatic int unsigned nbytes(input int unsigned sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int unsigned a, input int unsigned sz, input bit uns);
    int unsigned n = nbytes(sz);
    int unsigned v = 0;
    for (int unsigned i = 0; i < n; i++) v += 32'(ref_mem[a + i]) << (8 * i);
    if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  initial begin
    bit          g_d, g_if, e_err, e_we, issue_e;
    int unsigned a, sz, off;
    logic [31:0] w, e_addr, e_mask, e_wdata, nxt_data;
    forever begin
      @(negedge clk);
      g_d = 0; g_if = 0;
      if (rst_n) begin
`ifdef MEM_ARB_RR_EN
        if (d_req_valid && if_req_valid) begin g_d = (last_port == 0); g_if = !g_d; end
        else begin g_d = d_req_valid; g_if = if_req_valid; end
`else
        g_d = d_req_valid; g_if = if_req_valid && !d_req_valid;
`endif
      end
      issue_e = g_d || g_if;
      a   = g_d ? d_addr : if_addr;
      sz  = g_d ? 32'(d_size) : 2;
      e_we = g_d && d_we;
      w   = d_wdata;
      off = a % 4;
      e_err = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0) || ((a >> 16) != 0);
      e_addr = '0; e_mask = '0; e_wdata = '0; nxt_data = '0;
      if (issue_e) begin
        e_addr = (a >> 2) & 32'h3FFF;
        if (!e_err) begin
          if (e_we) begin
            e_mask  = (sz == 0) ? (32'd1 << off) : (sz == 1) ? (32'd3 << off) : 32'd15;
            e_wdata = (sz == 0) ? (w & 32'hFF) * 32'h01010101 :
                      (sz == 1) ? (w & 32'hFFFF) * 32'h00010001 : w;
          end else begin
            e_mask   = 15;
            nxt_data = model_load(a, sz, g_d && d_unsigned);
          end
        end
      end
      chk("if_req_ready", 32'(if_req_ready), 32'(g_if));
      chk("d_req_ready", 32'(d_req_ready), 32'(g_d));
      chk("mem_addr", 32'(mem_addr), e_addr);
      chk("mem_mask", 32'(mem_mask), e_mask);
      chk("mem_write", 32'(mem_write), 32'(issue_e && !e_err && e_we));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("if_resp_valid", 32'(if_resp_valid), 32'(cur_v && cur_port == 0));
      chk("d_resp_valid", 32'(d_resp_valid), 32'(cur_v && cur_port == 1));
      chk("if_resp_err", 32'(if_resp_err), 32'(cur_v && cur_port == 0 && cur_err));
      chk("d_resp_err", 32'(d_resp_err), 32'(cur_v && cur_port == 1 && cur_err));
      chk("if_resp_data", if_resp_data, (cur_v && cur_port == 0) ? cur_data : 32'h0);
      chk("d_resp_data", d_resp_data, (cur_v && cur_port == 1) ? cur_data : 32'h0);
      @(posedge clk);
      if (rst_n && issue_e) begin
        if (e_we && !e_err)
          for (int unsigned i = 0; i < nbytes(sz); i++) ref_mem[a + i] = 8'((w >> (8 * i)) & 32'hFF);
        last_port = g_d ? 1 : 0;
        cur_v = 1; cur_port = g_d; cur_err = e_err; cur_data = nxt_data;
      end else begin
        cur_v = 0;
        if (!rst_n) last_port = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle(); @(posedge clk); #1; endtask
  task automatic idle(); d_req_valid = 0; if_req_valid = 0; endtask
  task automatic d_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] w);
    d_req_valid = 1; d_addr = a; d_we = we; d_size = sz; d_unsigned = uns; d_wdata = w;
  endtask
  task automatic if_req(input logic [31:0] a); if_req_valid = 1; if_addr = a; endtask

  initial begin
    logic [3:0] dpat;
    logic [3:0] exp_dpat;
    rst_n = 0;
    idle(); d_addr = '0; d_we = 0; d_size = 2'b10; d_unsigned = 0; d_wdata = '0;
    if_req(32'h10);
    @(negedge clk);
    chk("rst if_req_ready", 32'(if_req_ready), 0);
    chk("rst mem_mask", 32'(mem_mask), 0);
    chk("rst if_resp_valid", 32'(if_resp_valid), 0);
    @(posedge clk); #1 idle();
    #1 rst_n = 1;

    // store word then load word
    next_cycle(); d_req(32'h10, 1, 2'b10, 0, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_w mem_addr", 32'(mem_addr), 4);
    chk("st_w mem_mask", 32'(mem_mask), 32'hF);
    chk("st_w mem_write", 32'(mem_write), 1);
    next_cycle(); d_req(32'h10, 0, 2'b10, 0, 0);
    @(negedge clk);
    chk("st_w resp_valid", 32'(d_resp_valid), 1);
    chk("st_w resp_data", d_resp_data, 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("ld_w resp_data", d_resp_data, 32'hDEADBEEF);

    // store byte, signed and unsigned byte loads
    next_cycle(); d_req(32'h13, 1, 2'b00, 0, 32'h000000A5);
    @(negedge clk);
    chk("st_b mem_mask", 32'(mem_mask), 32'h8);
    chk("st_b mem_wdata", mem_wdata, 32'hA5A5A5A5);
    next_cycle(); d_req(32'h13, 0, 2'b00, 0, 0);
    next_cycle(); d_req(32'h13, 0, 2'b00, 1, 0);
    @(negedge clk);
    chk("ld_b signed", d_resp_data, 32'hFFFFFFA5);
    next_cycle(); idle();
    @(negedge clk);
    chk("ld_b unsigned", d_resp_data, 32'h000000A5);

    // misaligned half store
    next_cycle(); d_req(32'h21, 1, 2'b01, 0, 32'h1234);
    @(negedge clk);
    chk("st_h_mis ready", 32'(d_req_ready), 1);
    chk("st_h_mis mem_mask", 32'(mem_mask), 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("st_h_mis resp_err", 32'(d_resp_err), 1);
    chk("st_h_mis resp_data", d_resp_data, 0);

    // aligned half store/load, other faults (model-checked)
    next_cycle(); d_req(32'h22, 1, 2'b01, 0, 32'hCAFE8001);
    next_cycle(); d_req(32'h22, 0, 2'b01, 0, 0);
    next_cycle(); d_req(32'h12, 0, 2'b10, 0, 0);
    @(negedge clk);
    chk("ld_h signed", d_resp_data, 32'hFFFF8001);
    next_cycle(); d_req(32'h0002_0000, 1, 2'b10, 0, 32'h55);
    next_cycle(); d_req(32'h10, 0, 2'b11, 0, 0);
    next_cycle(); d_req(32'hFFFC, 0, 2'b10, 0, 0);

    // out-of-range fetch
    next_cycle(); idle(); if_req(32'h0001_0000);
    @(negedge clk);
    chk("if_oor ready", 32'(if_req_ready), 1);
    chk("if_oor mem_mask", 32'(mem_mask), 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("if_oor resp_err", 32'(if_resp_err), 1);

    // contention for 4 cycles
    next_cycle(); d_req(32'h10, 0, 2'b10, 0, 0); if_req(32'h40);
    dpat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dpat[i] = d_req_ready;
      if (i < 3) next_cycle();
    end
`ifdef MEM_ARB_RR_EN
    exp_dpat = 4'b0101;
`else
    exp_dpat = 4'b1111;
`endif
    chk("contend d grants", 32'(dpat), 32'(exp_dpat));
    next_cycle(); d_req_valid = 0;
    @(negedge clk);
    chk("contend if granted", 32'(if_req_ready), 1);
    next_cycle(); idle();

    // reset during an in-flight fetch
    next_cycle(); if_req(32'h10);
    @(negedge clk);
    chk("rst_mid issue", 32'(if_req_ready), 1);
    #2 rst_n = 0;
    #1 idle();
    @(negedge clk);
    chk("rst_mid if_resp_valid", 32'(if_resp_valid), 0);
    chk("rst_mid mem_mask", 32'(mem_mask), 0);
    @(posedge clk); #2 rst_n = 1;
    next_cycle(); if_req(32'h10);
    next_cycle(); idle();
    @(negedge clk);
    chk("post_rst fetch", if_resp_data, 32'hA5ADBEEF);
    chk("post_rst resp_valid", 32'(if_resp_valid), 1);

    repeat (3) next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
